// File: rtl/wb_addr_gen_pkg.sv
// Shared types and default constants for the write-address generator.
// The frame FSM state type lives here so the top and any checkers agree on it.
package wb_addr_gen_pkg;

    localparam int DEF_NUM_BITS  = 8;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_FRAME_LEN = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } frame_state_e;

endpackage

// File: rtl/wb_addr_fifo.sv
// Address FIFO holding read addresses until their results return.
// Decides push/pop acceptance itself so a full FIFO can still accept a push alongside a pop.
module wb_addr_fifo #(
    parameter int NUM_BITS = 8,
    parameter int DEPTH    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [NUM_BITS-1:0]        push_data,
    input  logic                       pop,
    output logic                       push_ok,
    output logic                       pop_ok,
    output logic [NUM_BITS-1:0]        head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [NUM_BITS-1:0] mem_r [DEPTH];
    logic [PW-1:0]       wr_ptr_r;
    logic [PW-1:0]       rd_ptr_r;
    logic [CW-1:0]       count_r;

    // Acceptance: pop needs data present; push needs room, which a same-cycle pop provides.
    always_comb begin
        pop_ok  = 1'b0;
        push_ok = 1'b0;
        if (pop && (count_r != {CW{1'b0}})) begin
            pop_ok = 1'b1;
        end else begin
            pop_ok = 1'b0;
        end
        if (push && ((count_r < CW'(DEPTH)) || pop_ok)) begin
            push_ok = 1'b1;
        end else begin
            push_ok = 1'b0;
        end
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/wb_addr_gen.sv
// Write-address generator: replays captured read addresses as write addresses when results return.
// Optional macro WB_ADDR_GEN_ERR_FLAGS_EN enables the sticky ovf/udf flags (constant 0 otherwise).
module wb_addr_gen
    import wb_addr_gen_pkg::*;
#(
    parameter int NUM_BITS  = DEF_NUM_BITS,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd_en,
    input  logic [NUM_BITS-1:0]    rd_addr,
    input  logic                   res_valid,
    output logic                   wr_en,
    output logic [NUM_BITS-1:0]    wr_addr,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   frame_done,
    output logic                   ovf,
    output logic                   udf
);

    // Counter must reach FRAME_LEN, which may equal 2^NUM_BITS.
    localparam int          FC_W        = NUM_BITS + 1;
    localparam logic [FC_W-1:0] FRAME_LEN_C = FC_W'(FRAME_LEN);

    logic                push_ok_s;
    logic                pop_ok_s;
    logic [NUM_BITS-1:0] head_s;

    frame_state_e        state_r;
    frame_state_e        state_nxt_s;
    logic [FC_W-1:0]     frame_cnt_r;
    logic [FC_W-1:0]     frame_cnt_nxt_s;
    logic                frame_hit_s;

    wb_addr_fifo #(
        .NUM_BITS (NUM_BITS),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_en),
        .push_data (rd_addr),
        .pop       (res_valid),
        .push_ok   (push_ok_s),
        .pop_ok    (pop_ok_s),
        .head      (head_s),
        .count     (outstanding)
    );

    // Frame FSM next-state: the first pop of a frame counts as write number one.
    always_comb begin
        state_nxt_s     = state_r;
        frame_cnt_nxt_s = frame_cnt_r;
        frame_hit_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (pop_ok_s) begin
                    if (FRAME_LEN_C == FC_W'(1)) begin
                        frame_hit_s     = 1'b1;
                        frame_cnt_nxt_s = {FC_W{1'b0}};
                        state_nxt_s     = IDLE;
                    end else begin
                        frame_cnt_nxt_s = FC_W'(1);
                        state_nxt_s     = RUN;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (pop_ok_s) begin
                    if ((frame_cnt_r + FC_W'(1)) == FRAME_LEN_C) begin
                        frame_hit_s     = 1'b1;
                        frame_cnt_nxt_s = {FC_W{1'b0}};
                        state_nxt_s     = IDLE;
                    end else begin
                        frame_cnt_nxt_s = frame_cnt_r + FC_W'(1);
                        state_nxt_s     = RUN;
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                frame_cnt_nxt_s = {FC_W{1'b0}};
            end
        endcase
    end

    // State, counter and registered write-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            frame_cnt_r <= {FC_W{1'b0}};
            wr_en       <= 1'b0;
            wr_addr     <= {NUM_BITS{1'b0}};
            frame_done  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            frame_cnt_r <= frame_cnt_nxt_s;
            wr_en       <= pop_ok_s;
            frame_done  <= frame_hit_s;
            if (pop_ok_s) begin
                wr_addr <= head_s;
            end
        end
    end

`ifdef WB_ADDR_GEN_ERR_FLAGS_EN
    // Sticky error flags: a refused push is overflow, a refused pop is underflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (rd_en && !push_ok_s) begin
                ovf <= 1'b1;
            end
            if (res_valid && !pop_ok_s) begin
                udf <= 1'b1;
            end
        end
    end
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_wb_addr_gen.sv
// Self-checking bench for wb_addr_gen: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_wb_addr_gen;

    localparam int NUM_BITS  = 8;
    localparam int DEPTH     = 8;
    localparam int FRAME_LEN = 4;
    localparam int CW        = $clog2(DEPTH) + 1;
`ifdef WB_ADDR_GEN_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                rd_en = 1'b0;
    logic [NUM_BITS-1:0] rd_addr = '0;
    logic                res_valid = 1'b0;
    logic                wr_en;
    logic [NUM_BITS-1:0] wr_addr;
    logic [CW-1:0]       outstanding;
    logic                frame_done;
    logic                ovf;
    logic                udf;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [NUM_BITS-1:0] q[$];
    logic                exp_wr_en = 1'b0;
    logic [NUM_BITS-1:0] exp_wr_addr = '0;
    logic                exp_fd = 1'b0;
    logic                exp_ovf = 1'b0;
    logic                exp_udf = 1'b0;
    int                  writes_in_frame = 0;
    int                  max_out = 0;

    wb_addr_gen #(
        .NUM_BITS  (NUM_BITS),
        .DEPTH     (DEPTH),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .res_valid   (res_valid),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .outstanding (outstanding),
        .frame_done  (frame_done),
        .ovf         (ovf),
        .udf         (udf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic [NUM_BITS-1:0] a,
                                input logic v, input logic rs);
        bit pop_ok;
        bit push_ok;
        if (rs) begin
            q.delete();
            exp_wr_en = 1'b0;
            exp_wr_addr = '0;
            exp_fd = 1'b0;
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
            writes_in_frame = 0;
        end else begin
            pop_ok  = v && (q.size() > 0);
            push_ok = r && ((q.size() < DEPTH) || pop_ok);
            exp_wr_en = pop_ok;
            exp_fd = 1'b0;
            if (pop_ok) begin
                exp_wr_addr = q.pop_front();
                writes_in_frame++;
                if (writes_in_frame == FRAME_LEN) begin
                    exp_fd = 1'b1;
                    writes_in_frame = 0;
                end
            end
            if (push_ok) q.push_back(a);
            if (ERR_EN && r && !push_ok) exp_ovf = 1'b1;
            if (ERR_EN && v && !pop_ok) exp_udf = 1'b1;
        end
        if (q.size() > max_out) max_out = q.size();
    endtask

    task automatic step(input logic r, input logic [NUM_BITS-1:0] a,
                        input logic v, input logic rs);
        @(negedge clk);
        rd_en = r;
        rd_addr = a;
        res_valid = v;
        reset = rs;
        @(posedge clk);
        model_update(r, a, v, rs);
        #1;
        check_eq("wr_en", 32'(wr_en), 32'(exp_wr_en));
        check_eq("wr_addr", 32'(wr_addr), 32'(exp_wr_addr));
        check_eq("outstanding", 32'(outstanding), 32'(q.size()));
        check_eq("frame_done", 32'(frame_done), 32'(exp_fd));
        check_eq("ovf", 32'(ovf), 32'(exp_ovf));
        check_eq("udf", 32'(udf), 32'(exp_udf));
    endtask

    initial begin
        int fd_count;
        // Reset with active inputs: reset must win
        step(1'b1, 8'd77, 1'b1, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b1);

        // Basic in-order replay of 1..4
        max_out = 0;
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b1, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        check_eq("peak_out", 32'(max_out), 32'd4);
        check_eq("end_out", 32'(outstanding), 32'd0);

        // Overflow: push 10..18, 18 dropped
        step(1'b0, 8'd0, 1'b0, 1'b1);
        for (int i = 10; i <= 18; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        check_eq("ovf_full", 32'(outstanding), 32'd8);
        check_eq("ovf_flag", 32'(ovf), 32'(ERR_EN));
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'd0, 1'b1, 1'b0);
            check_eq("ovf_order", 32'(wr_addr), 32'(10 + i));
        end
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check_eq("no_18", 32'(wr_en), 32'd0);

        // Underflow with same-cycle push of 5
        step(1'b0, 8'd0, 1'b0, 1'b1);
        step(1'b1, 8'd5, 1'b1, 1'b0);
        check_eq("udf_noen", 32'(wr_en), 32'd0);
        check_eq("udf_flag", 32'(udf), 32'(ERR_EN));
        check_eq("udf_out", 32'(outstanding), 32'd1);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check_eq("udf_wr5", 32'(wr_addr), 32'd5);

        // Full FIFO with push 99 and pop together
        step(1'b0, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(40 + i), 1'b0, 1'b0);
        step(1'b1, 8'd99, 1'b1, 1'b0);
        check_eq("full_rw_ovf", 32'(ovf), 32'd0);
        check_eq("full_rw_out", 32'(outstanding), 32'd8);
        for (int i = 0; i < 8; i++) step(1'b0, 8'd0, 1'b1, 1'b0);
        check_eq("last_99", 32'(wr_addr), 32'd99);

        // Frames: 8 pushes then 8 pops, done on 4th and 8th writes
        step(1'b0, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(i + 100), 1'b0, 1'b0);
        fd_count = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 8'd0, 1'b1, 1'b0);
            check_eq("frame_pulse", 32'(frame_done), 32'((i % 4) == 0));
            fd_count += int'(frame_done);
        end
        check_eq("frame_count", 32'(fd_count), 32'd2);

        // Reset with 3 outstanding discards them
        for (int i = 0; i < 3; i++) step(1'b1, 8'(i + 60), 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b1);
        check_eq("rst_out", 32'(outstanding), 32'd0);
        check_eq("rst_wa", 32'(wr_addr), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b1, 1'b0);

        // Random traffic
        step(1'b0, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 9) < 6), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
